// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: executes START / STOP / WRITE / READ commands as
// quarter-phased SCL/SDA sequences on open-drain lines, with clock stretching.
module i2c_byte_master #(
  parameter int CLK_DIV        = 4,
  parameter int I2C_DATA_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [I2C_DATA_WIDTH-1:0] cmd_data_i,
  input  logic                      cmd_nack_i,
  output logic                      rsp_valid_o,
  output logic [I2C_DATA_WIDTH-1:0] rsp_data_o,
  output logic                      rsp_nack_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_oe_o,
  output logic                      sda_oe_o
);

  localparam int                 BW       = $clog2(I2C_DATA_WIDTH + 1);
  localparam logic [15:0]        CNT_LAST = 16'(CLK_DIV - 1);
  localparam logic [BW-1:0]      ACK_IDX  = BW'(I2C_DATA_WIDTH);
  localparam logic [1:0]         OP_START = 2'b00;
  localparam logic [1:0]         OP_STOP  = 2'b01;
  localparam logic [1:0]         OP_WRITE = 2'b10;
  localparam logic [1:0]         OP_READ  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_RSP} state_t;

  state_t                    state;
  logic [1:0]                q;
  logic [15:0]               cnt;
  logic [BW-1:0]             bit_idx;
  logic                      is_read;
  logic                      ack_nack;
  logic                      ack_sample;
  logic [I2C_DATA_WIDTH-1:0] shreg;

  logic accept;
  logic cmd_legal;
  logic stall;
  logic q_last;

  assign accept    = cmd_valid_i && cmd_ready_o;
  assign cmd_legal = (cmd_op_i == OP_START) || busy_o;
  // A slave holding SCL low while we release it freezes the quarter counter.
  assign stall     = (q == 2'd1) && !scl_i;
  assign q_last    = (cnt == CNT_LAST) && !stall;

  // SDA pull-down for one bit: data bits for WRITE, ACK bit for READ.
  function automatic logic bit_drive(input logic rd, input logic ack,
                                     input logic data_msb, input logic nack);
    if (ack) return rd ? !nack : 1'b0;
    return rd ? 1'b0 : !data_msb;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      q           <= 2'd0;
      cnt         <= '0;
      bit_idx     <= '0;
      is_read     <= 1'b0;
      ack_nack    <= 1'b0;
      ack_sample  <= 1'b0;
      shreg       <= '0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_nack_o  <= 1'b0;
      rsp_err_o   <= 1'b0;
      busy_o      <= 1'b0;
      scl_oe_o    <= 1'b0;
      sda_oe_o    <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        S_IDLE, S_RSP: begin
          state <= S_IDLE;
          if (accept) begin
            q   <= 2'd0;
            cnt <= '0;
            if (!cmd_legal) begin
              state       <= S_RSP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end else begin
              cmd_ready_o <= 1'b0;
              case (cmd_op_i)
                OP_START: begin
                  state    <= S_START;
                  sda_oe_o <= 1'b0;
                end
                OP_STOP: begin
                  state    <= S_STOP;
                  scl_oe_o <= 1'b1;
                  sda_oe_o <= 1'b1;
                end
                OP_WRITE, OP_READ: begin
                  state    <= S_BIT;
                  bit_idx  <= '0;
                  is_read  <= (cmd_op_i == OP_READ);
                  ack_nack <= cmd_nack_i;
                  shreg    <= cmd_data_i;
                  scl_oe_o <= 1'b1;
                  sda_oe_o <= bit_drive(cmd_op_i == OP_READ, 1'b0,
                                        cmd_data_i[I2C_DATA_WIDTH-1], cmd_nack_i);
                end
                default: state <= S_IDLE;
              endcase
            end
          end
        end
        default: begin
          if (!stall) cnt <= q_last ? '0 : cnt + 16'd1;
          if (q_last) q <= q + 2'd1;
          if (state == S_BIT && q == 2'd2 && q_last) begin
            if (bit_idx == ACK_IDX) ack_sample <= sda_i;
            else shreg <= {shreg[I2C_DATA_WIDTH-2:0], sda_i};
          end
          if (q_last) begin
            case (q)
              2'd0: scl_oe_o <= 1'b0;
              2'd1: begin
                if (state == S_START) sda_oe_o <= 1'b1;
                else if (state == S_STOP) sda_oe_o <= 1'b0;
              end
              2'd2: if (state != S_STOP) scl_oe_o <= 1'b1;
              default: begin
                if (state == S_BIT && bit_idx != ACK_IDX) begin
                  bit_idx  <= bit_idx + BW'(1);
                  sda_oe_o <= bit_drive(is_read, (bit_idx + BW'(1)) == ACK_IDX,
                                        shreg[I2C_DATA_WIDTH-1], ack_nack);
                end else begin
                  state       <= S_RSP;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  if (state == S_START) busy_o <= 1'b1;
                  if (state == S_STOP) busy_o <= 1'b0;
                  if (state == S_BIT) begin
                    if (is_read) rsp_data_o <= shreg;
                    else rsp_nack_o <= ack_sample;
                  end
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: per-cycle comparison against a quarter-phase
// waveform model, a behavioural open-drain slave, and literal anchor checks.
module tb_i2c_byte_master;
  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_nack = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_nack, rsp_err, busy;
  logic [7:0] rsp_data;
  logic       scl, sda, scl_oe, sda_oe;

  i2c_byte_master #(.CLK_DIV(CD), .I2C_DATA_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .cmd_nack_i(cmd_nack),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_nack_o(rsp_nack),
    .rsp_err_o(rsp_err), .busy_o(busy), .scl_i(scl), .sda_i(sda),
    .scl_oe_o(scl_oe), .sda_oe_o(sda_oe));

  always #5 clk = ~clk;

  // Slave: bit index counted by SCL falling edges since the byte command began.
  logic       slave_on = 1'b0;
  logic [8:0] slave_bits = '1;
  int         fall_count = 0, fall_base = 0;
  int         held_total = 0, held_base = 0;
  int         stretch_bit = -1, stretch_n = 0;
  logic       scl_prev = 1'b1;
  logic [8:0] rise_sh = '0;
  logic       hold, slave_low;

  always_comb begin
    hold      = slave_on && ((fall_count - fall_base) == stretch_bit) &&
                ((held_total - held_base) < stretch_n);
    slave_low = 1'b0;
    if (slave_on && (fall_count - fall_base) < 9)
      slave_low = !slave_bits[8 - (fall_count - fall_base)];
  end

  assign scl = !scl_oe && !hold;
  assign sda = !sda_oe && !slave_low;

  always @(posedge clk) begin
    scl_prev <= scl;
    if (scl_prev && !scl) fall_count <= fall_count + 1;
    if (!scl_prev && scl) rise_sh <= {rise_sh[7:0], sda};
    if (hold && !scl_oe) held_total <= held_total + 1;
  end

  // Model expectations
  logic       exp_scl = 0, exp_sda = 0, exp_ready = 1, exp_rsp = 0, exp_busy = 0, exp_err = 0;
  logic       chk_nack = 0, chk_data = 0, exp_nack = 0;
  logic [7:0] exp_data = 0;
  logic [1:0] wave[$];
  int         checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h exp %0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("scl_oe", {31'd0, scl_oe}, {31'd0, exp_scl});
    check("sda_oe", {31'd0, sda_oe}, {31'd0, exp_sda});
    check("cmd_ready", {31'd0, cmd_ready}, {31'd0, exp_ready});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rsp});
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    if (exp_rsp) begin
      check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
      if (chk_nack) check("rsp_nack", {31'd0, rsp_nack}, {31'd0, exp_nack});
      if (chk_data) check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_data});
    end
  end

  task automatic push_n(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) wave.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      exp_rsp = 0; chk_nack = 0; chk_data = 0;
    end
  endtask

  // Issue one command in the current cycle and follow it to its response.
  task automatic exec(input logic [1:0] op, input logic [7:0] d, input logic nk,
                      input logic [8:0] slv, input int sbit, input int sn,
                      input int abort_k, input bit noise, output int lat);
    bit   legal;
    logic dr;
    legal = (op == 2'b00) || exp_busy;
    wave.delete();
    if (legal) begin
      case (op)
        2'b00: begin
          push_n({exp_scl, 1'b0}, CD); push_n(2'b00, CD); push_n(2'b01, CD); push_n(2'b11, CD);
        end
        2'b01: begin
          push_n(2'b11, CD); push_n(2'b01, CD); push_n(2'b00, CD); push_n(2'b00, CD);
        end
        default: begin
          for (int b = 0; b < 9; b++) begin
            if (b == 8) dr = (op == 2'b11) ? !nk : 1'b0;
            else        dr = (op == 2'b11) ? 1'b0 : !d[7-b];
            push_n({1'b1, dr}, CD);
            push_n({1'b0, dr}, CD + ((b == sbit) ? sn : 0));
            push_n({1'b0, dr}, CD);
            push_n({1'b1, dr}, CD);
          end
        end
      endcase
    end
    cmd_valid = 1; cmd_op = op; cmd_data = d; cmd_nack = nk;
    @(posedge clk); #1;
    cmd_valid = 0;
    if (legal && op[1]) begin
      slave_bits = slv; fall_base = fall_count; held_base = held_total;
      stretch_bit = sbit; stretch_n = sn; slave_on = 1;
    end
    exp_rsp = 0; chk_nack = 0; chk_data = 0;
    lat = 0;
    for (int k = 1; k <= wave.size(); k++) begin
      {exp_scl, exp_sda} = wave[k-1];
      exp_ready = 0;
      if (rsp_valid && lat == 0) lat = k;
      if (noise) begin
        cmd_valid = 1'($urandom_range(0, 1)); cmd_op = 2'($urandom);
        cmd_data = 8'($urandom); cmd_nack = 1'($urandom);
      end
      if (k == abort_k) begin
        #1; rst = 1;
        exp_scl = 0; exp_sda = 0; exp_ready = 1; exp_rsp = 0; exp_busy = 0;
        slave_on = 0; cmd_valid = 0;
        #1;
        check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        wave.delete();
        return;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    if (rsp_valid && lat == 0) lat = wave.size() + 1;
    exp_rsp = 1; exp_ready = 1; exp_err = !legal;
    if (legal) begin
      if (op == 2'b00) exp_busy = 1;
      if (op == 2'b01) exp_busy = 0;
      if (op == 2'b10) begin chk_nack = 1; exp_nack = slv[0]; end
      if (op == 2'b11) begin chk_data = 1; exp_data = slv[8:1]; end
    end
    slave_on = 0;
    wave.delete();
  endtask

  int   lat;
  logic [1:0] rop;
  logic [7:0] rd;
  logic [8:0] rslv;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("init_ready", {31'd0, cmd_ready}, 32'd1);
    check("init_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("init_rsp_nack", {31'd0, rsp_nack}, 32'd0);
    check("init_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 0;

    // Illegal commands while idle: first edge after reset accepts
    exec(2'b10, 8'h12, 0, 9'h1FF, -1, 0, 0, 0, lat);
    check("lat_illegal_write", lat, 1);
    check("err_illegal_write", {31'd0, rsp_err}, 32'd1);
    exec(2'b01, 8'h00, 0, 9'h1FF, -1, 0, 0, 0, lat);
    check("lat_illegal_stop", lat, 1);
    idle(1);
    exec(2'b11, 8'h00, 0, 9'h1FF, -1, 0, 0, 0, lat);
    check("lat_illegal_read", lat, 1);

    // START then WRITE 0x5A with ACK, back to back
    idle(2);
    exec(2'b00, 8'h00, 0, 9'h1FF, -1, 0, 0, 0, lat);
    check("lat_start", lat, 17);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    exec(2'b10, 8'h5A, 0, {8'hFF, 1'b0}, -1, 0, 0, 0, lat);
    check("lat_write", lat, 145);
    check("nack_write_ack", {31'd0, rsp_nack}, 32'd0);
    check("sda_at_rise", {23'd0, rise_sh}, 32'h0B4);

    exec(2'b10, 8'hFF, 0, 9'h1FF, -1, 0, 0, 1, lat);
    check("nack_write_ff", {31'd0, rsp_nack}, 32'd1);
    check("err_write_ff", {31'd0, rsp_err}, 32'd0);

    idle(1);
    exec(2'b11, 8'h00, 1, {8'hC3, 1'b1}, -1, 0, 0, 1, lat);
    check("read_c3", {24'd0, rsp_data}, 32'hC3);

    exec(2'b10, 8'h96, 0, {8'hFF, 1'b0}, 3, 10, 0, 0, lat);
    check("lat_stretch", lat, 155);

    exec(2'b00, 8'h00, 0, 9'h1FF, -1, 0, 0, 0, lat);
    exec(2'b01, 8'h00, 0, 9'h1FF, -1, 0, 0, 0, lat);
    check("lat_stop", lat, 17);
    check("busy_after_stop", {31'd0, busy}, 32'd0);

    // Randomized command stream
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 2));
      rop = 2'($urandom);
      rd  = 8'($urandom);
      rslv = (rop == 2'b10) ? {8'hFF, 1'($urandom)} : 9'($urandom);
      exec(rop, rd, 1'($urandom), rslv,
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1,
           $urandom_range(1, 6), 0, 1'($urandom), lat);
    end

    // Reset during bit 5 of a READ
    idle(1);
    exec(2'b00, 8'h00, 0, 9'h1FF, -1, 0, 0, 0, lat);
    exec(2'b11, 8'h00, 0, {8'hA5, 1'b1}, -1, 0, 82, 0, lat);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    exec(2'b00, 8'h00, 0, 9'h1FF, -1, 0, 0, 0, lat);
    check("lat_start_after_rst", lat, 17);
    exec(2'b01, 8'h00, 0, 9'h1FF, -1, 0, 0, 0, lat);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
